inv_vec_mult: RTL and testbench

INV_VEC_MULT -- requirements
Module: inv_vec_mult

---
 rtl/inv_vec_mult_if.sv | 51 +++++
 rtl/inv_vec_mult.sv | 189 ++++++++++++++++++
 tb/tb_inv_vec_mult.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_vec_mult_if.sv
// ----------------------------------------------------------------------------
// inv_vec_mult_if
// Bundles the job-input and result-output handshakes of inv_vec_mult.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge
// where valid and ready are both 1. The producer holds valid and its payload
// stable until that edge; ready may be asserted at any time.
//
// Signals:
//   in_valid / in_ready        job channel (producer -> block)
//   a_inv..d_inv               2x2 inverse matrix coefficients, signed
//   inv_error                  upstream inverter flagged a singular matrix
//   y0, y1                     right-hand-side vector, signed
//   out_valid / out_ready      result channel (block -> consumer)
//   x0, x1                     result x = A_inv * y, signed
//   out_err                    result belongs to a singular-matrix job
//   out_sat                    x0 or x1 was clipped
//
// Modports:
//   slave  : the inv_vec_mult block
//   master : the environment driving jobs and consuming results
// ----------------------------------------------------------------------------
interface inv_vec_mult_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_inv;
    logic [DATA_W-1:0] b_inv;
    logic [DATA_W-1:0] c_inv;
    logic [DATA_W-1:0] d_inv;
    logic              inv_error;
    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] y1;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] x0;
    logic [DATA_W-1:0] x1;
    logic              out_err;
    logic              out_sat;

    modport slave (
        input  in_valid, a_inv, b_inv, c_inv, d_inv, inv_error, y0, y1, out_ready,
        output in_ready, out_valid, x0, x1, out_err, out_sat
    );

    modport master (
        output in_valid, a_inv, b_inv, c_inv, d_inv, inv_error, y0, y1, out_ready,
        input  in_ready, out_valid, x0, x1, out_err, out_sat
    );
endinterface

// File: rtl/inv_vec_mult.sv
// ----------------------------------------------------------------------------
// inv_vec_mult
// Multiplies a 2x2 inverse matrix by a 2-element vector using one shared
// signed multiplier, four multiply-accumulate steps per job, round-half-up
// to the operand fixed-point format and saturation to DATA_W bits.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset (0 = in reset)
//   bus      inv_vec_mult_if.slave: job input and result output handshakes
//   state_o  current FSM state (debug visibility)
//
// Timing: a good job shows out_valid 4 edges after its accept edge; a job
// accepted with inv_error=1 shows out_valid 1 edge after accept. At least
// one idle cycle separates the output handshake from the next accept.
// ----------------------------------------------------------------------------
module inv_vec_mult #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    inv_vec_mult_if.slave         bus,
    output logic [1:0]            state_o
);
    localparam int ACC_W = 2 * DATA_W + 2;
    localparam logic signed [ACC_W-1:0] ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ROUND = ONE << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAXV  = (ONE << (DATA_W - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] MINV  = ~MAXV;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               step_q, step_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [DATA_W-1:0]        y0_q, y0_d, y1_q, y1_d;
    logic [DATA_W-1:0]        x0_q, x0_d, x1_q, x1_d;
    logic                     err_q, err_d;
    logic                     sat_q, sat_d;
    logic                     valid_q, valid_d;

    // Datapath: shared multiplier, accumulate, round and clip.
    logic signed [DATA_W-1:0]   coef, vec;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum, rnd;
    logic                       clip_hi, clip_lo;
    logic [DATA_W-1:0]          fin;

    always_comb begin
        // Step order: a*y0, b*y1 (x0), then c*y0, d*y1 (x1).
        case (step_q)
            2'd0:    coef = $signed(a_q);
            2'd1:    coef = $signed(b_q);
            2'd2:    coef = $signed(c_q);
            default: coef = $signed(d_q);
        endcase
        vec     = step_q[0] ? $signed(y1_q) : $signed(y0_q);
        prod    = coef * vec;
        sum     = acc_q + {{2{prod[2*DATA_W-1]}}, prod};
        // Adding half an LSB before the arithmetic shift gives round-half-up.
        rnd     = (sum + ROUND) >>> FRAC;
        clip_hi = (rnd > MAXV);
        clip_lo = (rnd < MINV);
        if (clip_hi) begin
            fin = MAXV[DATA_W-1:0];
        end else if (clip_lo) begin
            fin = MINV[DATA_W-1:0];
        end else begin
            fin = rnd[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        err_d   = err_q;
        sat_d   = sat_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a_inv;
                    b_d     = bus.b_inv;
                    c_d     = bus.c_inv;
                    d_d     = bus.d_inv;
                    y0_d    = bus.y0;
                    y1_d    = bus.y1;
                    err_d   = bus.inv_error;
                    sat_d   = 1'b0;
                    step_d  = 2'd0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (err_q) begin
                    // Singular job: skip the arithmetic and publish zeros on
                    // the first edge after accept.
                    x0_d    = '0;
                    x1_d    = '0;
                    sat_d   = 1'b0;
                    valid_d = 1'b1;
                    step_d  = 2'd0;
                    state_d = S_OUT;
                end else begin
                    step_d = step_q + 2'd1;
                    acc_d  = sum;
                    if (step_q == 2'd1) begin
                        x0_d  = fin;
                        sat_d = clip_hi | clip_lo;
                        acc_d = '0;
                    end else if (step_q == 2'd3) begin
                        x1_d    = fin;
                        sat_d   = sat_q | clip_hi | clip_lo;
                        acc_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.x0        = x0_q;
    assign bus.x1        = x1_q;
    // err/sat are only meaningful alongside out_valid; gate them so they read
    // 0 whenever no result is presented.
    assign bus.out_err   = valid_q & err_q;
    assign bus.out_sat   = valid_q & sat_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_inv_vec_mult.sv
// ----------------------------------------------------------------------------
// tb_inv_vec_mult
// Drives jobs into inv_vec_mult, keeps expected results in a queue and
// compares them in an independent monitor at each output handshake.
// ----------------------------------------------------------------------------
module tb_inv_vec_mult;
    localparam int W    = 16;
    localparam int FRAC = 14;
    localparam int EW   = 2 * W + 2;   // {err, sat, x0, x1}

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_o;

    always #5 clk = ~clk;

    inv_vec_mult_if #(.DATA_W(W)) bus ();

    inv_vec_mult #(.DATA_W(W), .FRAC(FRAC)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [EW-1:0] exp_q[$];
    bit          rdy_rand = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic err, input logic sat,
                                            input logic [W-1:0] x0, input logic [W-1:0] x1);
        return {err, sat, x0, x1};
    endfunction

    // Reference: exact integer dot products, round half up, saturate.
    function automatic logic [W:0] clip_val(input longint r);
        longint maxi, mini;
        maxi = (64'sd1 <<< (W - 1)) - 1;
        mini = -(64'sd1 <<< (W - 1));
        if (r > maxi) return {1'b1, maxi[W-1:0]};
        if (r < mini) return {1'b1, mini[W-1:0]};
        return {1'b0, r[W-1:0]};
    endfunction

    function automatic logic [EW-1:0] model(input logic [W-1:0] a, b, c, d, y0, y1,
                                             input logic err);
        longint s0, s1, r0, r1;
        logic [W:0] c0, c1;
        if (err) return pack(1'b1, 1'b0, '0, '0);
        s0 = longint'($signed(a)) * longint'($signed(y0)) + longint'($signed(b)) * longint'($signed(y1));
        s1 = longint'($signed(c)) * longint'($signed(y0)) + longint'($signed(d)) * longint'($signed(y1));
        r0 = (s0 + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        r1 = (s1 + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        c0 = clip_val(r0);
        c1 = clip_val(r1);
        return pack(1'b0, c0[W] | c1[W], c0[W-1:0], c1[W-1:0]);
    endfunction

    function automatic logic [W-1:0] rnd16();
        if ($urandom_range(0, 3) == 0) return W'($urandom);
        return W'(int'($urandom_range(0, 32767)) - 16384);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic scramble_inputs();
        bus.a_inv     = rnd16();
        bus.b_inv     = rnd16();
        bus.c_inv     = rnd16();
        bus.d_inv     = rnd16();
        bus.y0        = rnd16();
        bus.y1        = rnd16();
        bus.inv_error = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_in_ready(output bit ok);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        ok = bus.in_ready;
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    // Issues one job, checks accept-to-valid latency, returns once out_valid
    // is seen (1 time unit after the edge on which it rose).
    task automatic run_job(input logic [W-1:0] a, b, c, d, y0, y1,
                           input logic err, input logic [EW-1:0] exp);
        bit ok;
        int n;
        wait_in_ready(ok);
        if (!ok) return;
        bus.a_inv     = a;
        bus.b_inv     = b;
        bus.c_inv     = c;
        bus.d_inv     = d;
        bus.y0        = y0;
        bus.y1        = y1;
        bus.inv_error = err;
        bus.in_valid  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;              // accept edge
        // Later input activity must not disturb the captured job.
        scramble_inputs();
        bus.in_valid = 1'($urandom_range(0, 1));
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
            scramble_inputs();
        end
        bus.in_valid = 1'b0;
        check("latency", n, err ? 1 : 4);
        check("in_ready_busy", bus.in_ready, 0);
    endtask

    task automatic run_random_job();
        logic [W-1:0] a, b, c, d, y0, y1;
        logic e;
        a = rnd16(); b = rnd16(); c = rnd16(); d = rnd16();
        y0 = rnd16(); y1 = rnd16();
        e = ($urandom_range(0, 5) == 0);
        run_job(a, b, c, d, y0, y1, e, model(a, b, c, d, y0, y1, e));
    endtask

    // ---------------- out_ready randomiser ----------------
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("x0", $signed(bus.x0), $signed(e[2*W-1:W]));
                    check("x1", $signed(bus.x1), $signed(e[W-1:0]));
                    check("out_err", bus.out_err, e[EW-1]);
                    check("out_sat", bus.out_sat, e[EW-2]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [EW-1:0] snap;
        bit ok;
        int vio;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        scramble_inputs();
        bus.in_valid  = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_x0", bus.x0, 0);
        check("rst_x1", bus.x1, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_out_sat", bus.out_sat, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases with literal expectations.
        run_job(16'sd16384, 16'sd0, 16'sd0, 16'sd16384, 16'sd8192, -16'sd4096, 1'b0,
                pack(1'b0, 1'b0, 16'sd8192, -16'sd4096));
        run_job(16'sd16384, 16'sd8192, -16'sd8192, 16'sd16384, 16'sd16384, 16'sd16384, 1'b0,
                pack(1'b0, 1'b0, 16'sd24576, 16'sd8192));
        run_job(16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768, 16'sd32767, 16'sd32767, 1'b0,
                pack(1'b0, 1'b1, 16'sd32767, -16'sd32768));
        run_job(16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd8192, 16'sd0, 1'b0,
                pack(1'b0, 1'b0, 16'sd1, 16'sd0));
        run_job(16'sd1234, -16'sd777, 16'sd32767, 16'sd5, -16'sd20000, 16'sd300, 1'b1,
                pack(1'b1, 1'b0, 16'sd0, 16'sd0));

        // Back-pressure: hold out_ready low for three cycles.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_job(16'sd16384, 16'sd8192, -16'sd8192, 16'sd16384, 16'sd16384, 16'sd16384, 1'b0,
                pack(1'b0, 1'b0, 16'sd24576, 16'sd8192));
        snap = {bus.out_err, bus.out_sat, bus.x0, bus.x1};
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", {bus.out_err, bus.out_sat, bus.x0, bus.x1}, snap);
            check("stall_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;                  // handshake edge
        check("post_hs_in_ready", bus.in_ready, 1);
        check("post_hs_out_valid", bus.out_valid, 0);

        // Reset in the middle of a job: no result, correct job afterwards.
        wait_in_ready(ok);
        bus.a_inv = 16'sd16384; bus.b_inv = 16'sd0; bus.c_inv = 16'sd0; bus.d_inv = 16'sd16384;
        bus.y0 = 16'sd100; bus.y1 = 16'sd200; bus.inv_error = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;                  // accept
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_x0", bus.x0, 0);
        check("abort_x1", bus.x1, 0);
        check("abort_err", bus.out_err, 0);
        check("abort_sat", bus.out_sat, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        vio = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vio++;
        end
        check("abort_no_result", vio, 0);
        run_job(16'sd8192, 16'sd8192, 16'sd16384, -16'sd16384, 16'sd1000, -16'sd3000, 1'b0,
                pack(1'b0, 1'b0, -16'sd1000, 16'sd4000));

        // Randomised jobs with random back-pressure.
        rdy_rand = 1'b1;
        for (int j = 0; j < 200; j++) run_random_job();

        // Drain outstanding results.
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("drain_queue_empty", exp_q.size(), 0);
        end
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
